// File: rtl/uart_pkg.sv
// uart_pkg: widths and scheduler state encoding shared by the UART transmit path.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int GRANT_ID_W = 3;
    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_LAUNCH = 2'd1,
        SCHED_SEND   = 2'd2,
        SCHED_DRAIN  = 2'd3
    } sched_state_t;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational first-eligible search starting at rr_ptr with wrap.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]    req,
    input  logic [GRANT_ID_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [GRANT_ID_W-1:0] grant_idx,
    output logic                  any_grant
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [IW-1:0] sel;
    // Walk offsets from far to near so the nearest eligible index wins last.
    always_comb begin
        grant = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[sel]) begin
                grant = '0;
                grant[sel] = 1'b1;
                grant_idx = GRANT_ID_W'(sel);
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx among NUM_REQ byte sources,
// launching exactly one frame per grant and flagging launches that never see busy.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LAUNCH_TIMEOUT = 4095
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mask,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [GRANT_ID_W-1:0]          grant_id,
    output logic                           frame_done,
    output logic                           timeout_err
);
    localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAUNCH_TIMEOUT);

    sched_state_t state, state_nx;
    logic [GRANT_ID_W-1:0] rr_ptr, win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [UART_DATA_W-1:0] win_byte;
    logic [CNT_W-1:0] to_cnt;
    logic any_win, grant_now, launch_to;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid & req_mask),
        .rr_ptr    (rr_ptr),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .any_grant (any_win)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            win_byte |= req_data[i*UART_DATA_W +: UART_DATA_W] & {UART_DATA_W{win_oh[i]}};
    end

    // tx_start is gated by busy so a still-busy serializer never sees a fresh start.
    always_comb begin
        state_nx = state;
        grant_now = 1'b0;
        tx_start = (state == SCHED_LAUNCH) && !tx_busy;
        launch_to = tx_start && (to_cnt >= CNT_LAST);
        case (state)
            SCHED_IDLE: begin
                grant_now = any_win && !tx_busy;
                state_nx = grant_now ? SCHED_LAUNCH : SCHED_IDLE;
            end
            SCHED_LAUNCH: state_nx = tx_busy ? SCHED_SEND : (launch_to ? SCHED_IDLE : SCHED_LAUNCH);
            SCHED_SEND:   state_nx = tx_busy ? SCHED_SEND : SCHED_IDLE;
            default:      state_nx = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCHED_IDLE;
            rr_ptr <= '0;
            req_ready <= '0;
            tx_data <= '0;
            grant_id <= '0;
            frame_done <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt <= '0;
        end else begin
            state <= state_nx;
            req_ready <= grant_now ? win_oh : '0;
            frame_done <= (state == SCHED_SEND) && !tx_busy;
            timeout_err <= timeout_err | launch_to;
            to_cnt <= (state != SCHED_LAUNCH) ? '0 : ((to_cnt == CNT_MAX) ? to_cnt : to_cnt + 1'b1);
            if (grant_now) begin
                tx_data <= win_byte;
                grant_id <= win_idx;
                rr_ptr <= (win_idx == GRANT_ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed/random bench for uart_tx_sched with a behavioural
// uart_tx stand-in and a round-robin reference model.
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] req_valid = '0, req_mask = '0, req_ready;
    logic [7:0] dbyte [4];
    logic [31:0] req_data;
    logic tx_start, tx_busy, frame_done, timeout_err;
    logic [7:0] tx_data;
    logic [2:0] grant_id;
    logic uart_en = 1'b1;
    logic baud_tick;
    int bdiv = 0, bits_left = 0;

    int n_cmp = 0, n_err = 0, viol = 0, fd_cnt = 0, ptr = 0, efd = 0;
    int gq[$], eq[$];
    logic [7:0] dq[$], edq[$], sent_q[$], esq[$];
    logic [2:0] gidq[$];
    logic trk = 1'b0;
    logic [7:0] hold;

    assign req_data = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};
    assign baud_tick = (bdiv == 15);

    uart_tx_sched #(.NUM_REQ(4), .LAUNCH_TIMEOUT(20)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_mask(req_mask), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bdiv <= (bdiv == 15) ? 0 : bdiv + 1;

    // Serializer stand-in: samples tx_start on baud_tick, stays busy for 10 bit times.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy <= 1'b0;
            bits_left <= 0;
        end else if (baud_tick && uart_en) begin
            if (!tx_busy) begin
                if (tx_start) begin
                    tx_busy <= 1'b1;
                    bits_left <= 10;
                    sent_q.push_back(tx_data);
                end
            end else if (bits_left == 1) begin
                tx_busy <= 1'b0;
                bits_left <= 0;
            end else bits_left <= bits_left - 1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) trk = 1'b0;
        else begin
            if (tx_start && tx_busy) viol++;
            if (frame_done) fd_cnt++;
            if (req_ready != 0) begin
                if (!$onehot(req_ready)) viol++;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gq.push_back(i);
                gidq.push_back(grant_id);
                dq.push_back(tx_data);
                hold = tx_data;
                trk = 1'b1;
            end else if (trk) begin
                if (tx_data !== hold) viol++;
                if (tx_busy || !tx_start) trk = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] elig);
        for (int k = 0; k < 4; k++) if (elig[2'((ptr + k) % 4)]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic expect_grant(input logic [3:0] elig, input bit sent);
        int idx = pick(elig);
        eq.push_back(idx);
        edq.push_back(dbyte[2'(idx)]);
        if (sent) begin
            esq.push_back(dbyte[2'(idx)]);
            efd++;
        end
        ptr = (idx + 1) % 4;
    endtask

    task automatic wait_frames(input string tag, input int k);
        int seen = 0;
        for (int c = 0; c < k * 400 && seen < k; c++) begin
            @(negedge clk);
            if (frame_done) seen++;
        end
        chk(tag, seen, k);
    endtask

    task automatic check_grants(input string tag);
        chk({tag, "_ngrant"}, gq.size(), eq.size());
        foreach (eq[i]) if (i < gq.size()) begin
            chk({tag, "_idx"}, gq[i], eq[i]);
            chk({tag, "_gid"}, 32'(gidq[i]), eq[i]);
            chk({tag, "_data"}, 32'(dq[i]), 32'(edq[i]));
        end
        chk({tag, "_nsent"}, sent_q.size(), esq.size());
        foreach (esq[i]) if (i < sent_q.size()) chk({tag, "_sent"}, 32'(sent_q[i]), 32'(esq[i]));
        chk({tag, "_nframe"}, fd_cnt, efd);
        gq.delete(); gidq.delete(); dq.delete(); eq.delete(); edq.delete();
        sent_q.delete(); esq.delete();
        fd_cnt = 0;
        efd = 0;
    endtask

    task automatic randomize_bytes();
        for (int i = 0; i < 4; i++) dbyte[i] = 8'($urandom);
    endtask

    initial begin
        int n;
        randomize_bytes();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {req_ready, tx_start, tx_data, grant_id, frame_done, timeout_err}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single requester, fixed byte.
        dbyte[0] = 8'h55;
        req_mask = 4'hF;
        req_valid = 4'b0001;
        expect_grant(req_valid & req_mask, 1);
        @(negedge clk);
        chk("t1_ready_latency", req_ready, 4'b0001);
        chk("t1_start", tx_start, 1);
        req_valid = '0;
        wait_frames("t1_frame", 1);
        repeat (20) @(negedge clk);
        check_grants("t1");

        // All four requesters valid continuously.
        randomize_bytes();
        req_valid = 4'hF;
        for (int f = 0; f < 5; f++) expect_grant(4'hF, 1);
        wait_frames("t2_frames", 5);
        req_valid = '0;
        repeat (20) @(negedge clk);
        check_grants("t2");

        // Requester 3 masked, then unmasked.
        randomize_bytes();
        req_mask = 4'b0111;
        req_valid = 4'b1010;
        expect_grant(req_valid & req_mask, 1);
        expect_grant(req_valid & req_mask, 1);
        wait_frames("t3_masked", 2);
        req_mask = 4'hF;
        expect_grant(req_valid & req_mask, 1);
        wait_frames("t3_unmasked", 1);
        req_valid = '0;
        repeat (20) @(negedge clk);
        check_grants("t3");

        // Serializer absent: launch timeout.
        uart_en = 1'b0;
        randomize_bytes();
        req_valid = 4'b0001;
        expect_grant(req_valid, 0);
        @(negedge clk);
        chk("t4_ready", req_ready, 4'b0001);
        req_valid = '0;
        n = 0;
        while (tx_start && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t4_start_cycles", n, 20);
        chk("t4_timeout_err", timeout_err, 1);
        req_valid = 4'b0100;
        expect_grant(req_valid, 0);
        @(negedge clk);
        chk("t4_next_ready", req_ready, 4'b0100);
        req_valid = '0;
        repeat (40) @(negedge clk);
        chk("t4_sticky", timeout_err, 1);
        check_grants("t4");
        uart_en = 1'b1;

        // Reset in the middle of a frame with requests pending.
        randomize_bytes();
        req_valid = 4'b0110;
        for (int c = 0; c < 100 && !tx_busy; c++) @(negedge clk);
        chk("t5_busy", tx_busy, 1);
        repeat (48) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t5_reset_outputs", {req_ready, tx_start, tx_data, grant_id, frame_done, timeout_err}, 0);
        req_valid = 4'b0111;
        @(negedge clk);
        gq.delete(); gidq.delete(); dq.delete(); sent_q.delete();
        fd_cnt = 0;
        ptr = 0;
        reset_n = 1'b1;
        expect_grant(req_valid, 1);
        @(negedge clk);
        chk("t5_first_after_reset", req_ready, 4'b0001);
        wait_frames("t5_frame", 1);
        req_valid = '0;
        repeat (20) @(negedge clk);
        check_grants("t5");

        // Requester drops valid in its grant cycle.
        randomize_bytes();
        req_valid = 4'b0100;
        expect_grant(req_valid, 1);
        @(negedge clk);
        req_valid = '0;
        chk("t6_ready", req_ready, 4'b0100);
        wait_frames("t6_frame", 1);
        repeat (300) @(negedge clk);
        check_grants("t6");

        // All requesters masked off.
        req_mask = '0;
        req_valid = 4'hF;
        repeat (60) @(negedge clk);
        req_valid = '0;
        check_grants("t7");

        chk("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx serializer among NUM_REQ byte requesters.
- Accepts one byte per grant from a valid/ready interface and drives uart_tx's tx_start/data_in.
- Tracks uart_tx's busy to sequence exactly one frame per grant.
- Sits between the client blocks (command/status/log sources) and uart_tx. Shares clk and baud_tick domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LAUNCH_TIMEOUT, 4095, clk cycles allowed for uart_tx busy to rise after tx_start asserts.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  requester i byte on bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- req_mask  in  NUM_REQ  1 = requester enabled; masked requesters are never granted.
- tx_start  out  1  to uart_tx.
- tx_data  out  8  to uart_tx data_in.
- tx_busy  in  1  from uart_tx busy.
- grant_id  out  3  index of the current/last granted requester.
- frame_done  out  1  one-cycle pulse when a granted frame completes.
- timeout_err  out  1  sticky launch-timeout flag; cleared only by reset.

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, frame_done=0, timeout_err=0, state=IDLE, rr_ptr=0.
- States: IDLE, LAUNCH, SEND, DRAIN.
- IDLE:
  - Eligible requesters are req_valid & req_mask.
  - If any are eligible and tx_busy=0:
    - Grant the first eligible index searching upward from rr_ptr with wrap.
    - Latch req_data of the winner into tx_data and set grant_id.
    - Pulse req_ready[winner] for exactly one cycle.
    - Set rr_ptr = winner+1, wrapping to 0 at NUM_REQ.
    - Go to LAUNCH.
  - If tx_busy=1 (previous frame still clearing), wait.
- LAUNCH:
  - Hold tx_start=1 and tx_data stable.
  - uart_tx only samples on baud_tick, so hold tx_start for as many clk cycles as needed.
  - On tx_busy=1: deassert tx_start and go to SEND.
  - If LAUNCH_TIMEOUT cycles elapse without busy: deassert tx_start, set timeout_err, go to IDLE. The byte is dropped; the requester was already acked.
- SEND: wait for tx_busy=0, then pulse frame_done for one cycle and go to IDLE.
- DRAIN: unused encoding; any illegal state recovers to IDLE with tx_start=0.
- Latency: from req_valid rising with the scheduler idle, req_ready pulses 1 clk later (registered grant).
- tx_start must never be asserted while tx_busy=1 from a prior frame. Otherwise uart_tx would chain a frame with stale data_in.
- tx_data must not change between req_ready and tx_busy rising.
- Simultaneous events:
  - Multiple valid requesters: exactly one granted per frame, in strict round-robin order.
  - A requester deasserting req_valid in the same cycle as its grant is still granted; its data is latched that cycle.
- Mask changes take effect at the next IDLE arbitration only. A frame in flight is never aborted.
- req_mask all-zero: remain in IDLE, no req_ready pulses.
- reset_n low mid-frame: all outputs return to reset values immediately and rr_ptr returns to 0. The uart_tx shares reset, so the line returns idle.
- Timeout counter: width ceil(log2(LAUNCH_TIMEOUT+1)), cleared on entry to LAUNCH, saturating.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding localparams: SCHED_IDLE, SCHED_LAUNCH, SCHED_SEND, SCHED_DRAIN.
  - UART_DATA_W=8.
  - GRANT_ID_W=3.
- One sub-module, uart_rr_arbiter:
  - Purely combinational first-eligible-from-pointer search.
  - Input: request vector, rr_ptr. Output: one-hot grant, encoded index, any_grant.
  - Instantiated once.

Test Plan:
- Single requester 0, req_data=0x55, mask=4'b1111, baud_tick every 16 clk → one req_ready[0] pulse; tx_start held until busy rises; tx_data=0x55 throughout; frame_done after busy falls; line shows start, 10101010 LSB-first, stop.
- All four requesters valid continuously with data 0xA0..0xA3 → grant order 0,1,2,3,0; exactly one frame per grant; no tx_start while busy=1.
- Requesters 1 and 3 valid, mask=4'b0111 → only requester 1 is served; req_ready[3] never pulses; after the mask changes to 4'b1111, requester 3 is served next.
- tx_busy tied 0 (uart_tx absent), LAUNCH_TIMEOUT=20 → tx_start high for 20 clk then low; timeout_err=1 and stays 1; the next request is still arbitrated.
- reset_n asserted low midway through the data bits of a frame with requests pending → all outputs 0 immediately, rr_ptr=0; after release, requester 0 is granted first.
- Requester 2 drops req_valid in its grant cycle → byte still sent and frame_done pulses once.
